peripheral_bus_hub: RTL
=======================

# peripheral_bus_hub

Parametrised Wishbone-to-peripheral-bus hub that replaces the fixed bridge plus hand-written read-data priority mux in the peripheral subsystem. It decodes a device index from the Wishbone address and drives per-device one-hot strobes. It waits on per-device busy, with a timeout, and registers the selected device's read data. Unmapped or timed-out accesses are terminated with a Wishbone error instead of returning zero.

## Interface
Parameters:
- DEVICE_COUNT, 4: number of attached peripherals, 1..16.
- ADDR_WIDTH, 24: Wishbone and peripheral address width.
- DATA_WIDTH, 32: data width; a multiple of 8.
- DEVICE_SHIFT, 12: LSB of the 8-bit device index field in the address.
- TIMEOUT_CYCLES, 255: maximum number of ACCESS cycles with busy high before an error; 1..65535.

Ports:
- wb_clk_i  in  1  the single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone request.
- wb_sel_i  in  DATA_WIDTH/8  byte select.
- wb_adr_i  in  ADDR_WIDTH  address.
- wb_data_i  in  DATA_WIDTH  write data.
- wb_ack_o, wb_stall_o, wb_error_o  out  1 each  Wishbone response.
- wb_data_o  out  DATA_WIDTH  read data.
- pb_we  out  DEVICE_COUNT  one-hot write strobe.
- pb_oe  out  DEVICE_COUNT  one-hot read strobe.
- pb_address  out  ADDR_WIDTH  latched address, shared by all devices.
- pb_byteSelect  out  DATA_WIDTH/8  latched byte select.
- pb_dataWrite  out  DATA_WIDTH  latched write data.
- pb_busy  in  DEVICE_COUNT  per-device busy.
- pb_dataRead  in  DEVICE_COUNT*DATA_WIDTH  flattened read data; device i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- timeout_pulse  out  1  one-cycle pulse when an access times out.

## Operation
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - wb_stall_o=0.
  - On wb_cyc_i & wb_stb_i, latch we, sel, adr and data, and compute idx = adr[DEVICE_SHIFT +: 8].
  - idx < DEVICE_COUNT: go to ACCESS.
  - Otherwise: go to RESPOND with the error flag set.
- ACCESS:
  - wb_stall_o=1.
  - Assert pb_we[idx] (write) or pb_oe[idx] (read) continuously.
  - pb_busy[idx]=0 in any ACCESS cycle: capture pb_dataRead slice idx into a register and go to RESPOND.
  - Otherwise increment the timeout counter.
  - Counter reaches TIMEOUT_CYCLES: go to RESPOND with the error flag set and pulse timeout_pulse.
- RESPOND:
  - wb_stall_o=1.
  - Assert wb_ack_o (no error) or wb_error_o (error) for exactly one cycle; never both.
  - wb_data_o = captured data on a successful read; 0 otherwise.
  - Go to IDLE.
- wb_cyc_i dropped in ACCESS: abort to IDLE the next cycle, with no ack and no error; strobes deassert.
- A write with wb_sel_i=0 runs normally and is acked; the device sees pb_byteSelect=0.
- Busy from non-selected devices is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, data register 0. Reset mid-transaction returns to IDLE the next edge with no response.
- The request is accepted at edge 0. Strobe is visible in cycle 1. A device that is not busy gives ack/error in cycle 2, so minimum latency is 2 cycles.
- Each busy cycle adds one cycle of latency.
- A timeout gives an error at accept + TIMEOUT_CYCLES + 1.
- An unmapped address gives an error in cycle 1, with no strobe ever asserted.
- Back-to-back accesses are accepted, at the earliest, in the IDLE cycle after RESPOND: 3 cycles per access.
- The counter is 16 bits, cleared on every entry to ACCESS, and saturating.

## Structure
- Package peripheral_bus_pkg holds:
  - the state enum (IDLE, ACCESS, RESPOND);
  - the device-index field width (8);
  - the counter width (16).
- Sub-module peripheral_read_select: a combinational index-based slice selector for pb_dataRead. The capture register stays in the hub.

## Test plan
- Read device 2 (adr=0x002004) with busy low and pb_dataRead slice 2 = 0xDEADBEEF: pb_oe=4'b0100 in cycle 1, ack in cycle 2, wb_data_o=0xDEADBEEF.
- Write 0x12345678, sel=4'b0011 to device 1 with busy held for 3 cycles: pb_we=4'b0010 for 4 cycles, pb_byteSelect=0011, ack in cycle 5.
- Access to adr=0x00A000 (idx 10 ≥ 4): wb_error_o in cycle 1, pb_we/pb_oe stay 0, no ack.
- TIMEOUT_CYCLES=8 with device 0 busy forever: timeout_pulse and wb_error_o at cycle 9, strobe drops, next access accepted.
- Drop wb_cyc_i while device 3 is busy: no ack or error, IDLE the next cycle. Also assert wb_rst_i mid-ACCESS: all outputs 0 the next cycle.

Source files
------------

// File: rtl/peripheral_bus_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_bus_pkg
// Purpose  : Shared types and widths for the Wishbone peripheral bus hub.
//            Holds the hub state encoding, the device-index field width and
//            the timeout counter width.
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_bus_pkg;

  // Hub transaction states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // Width of the device index field taken from the Wishbone address
  localparam int IDX_WIDTH = 8;

  // Width of the saturating busy/timeout counter
  localparam int CNT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/peripheral_bus_hub_if.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_bus_hub_if
// Purpose  : Wishbone request/response bundle between a bus master and the
//            peripheral bus hub.
// Ports    : wb_stb_i/wb_cyc_i/wb_we_i/wb_sel_i/wb_adr_i/wb_data_i - request
//            wb_ack_o/wb_stall_o/wb_error_o/wb_data_o              - response
//            master modport drives requests, slave modport (hub) responds.
// Revision : 1.0 - initial release
// ============================================================================
interface peripheral_bus_hub_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
);

  logic                      wb_stb_i;
  logic                      wb_cyc_i;
  logic                      wb_we_i;
  logic [DATA_WIDTH/8-1:0]   wb_sel_i;
  logic [ADDR_WIDTH-1:0]     wb_adr_i;
  logic [DATA_WIDTH-1:0]     wb_data_i;
  logic                      wb_ack_o;
  logic                      wb_stall_o;
  logic                      wb_error_o;
  logic [DATA_WIDTH-1:0]     wb_data_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_ack_o, wb_stall_o, wb_error_o, wb_data_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_ack_o, wb_stall_o, wb_error_o, wb_data_o
  );

endinterface
`default_nettype wire

// File: rtl/peripheral_bus_hub_read_select.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_read_select
// Purpose  : Combinational selector returning the read-data slice of one
//            device from the flattened peripheral read bus.
// Ports    : idx      - device index
//            data_in  - flattened read data, device i at [i*DATA_WIDTH +: DATA_WIDTH]
//            data_out - selected slice (0 when idx is out of range)
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_read_select
  import peripheral_bus_pkg::*;
#(
  parameter int DEVICE_COUNT = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic [IDX_WIDTH-1:0]               idx,
  input  logic [DEVICE_COUNT*DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0]              data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < DEVICE_COUNT; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        data_out = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/peripheral_bus_hub.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_bus_hub
// Purpose  : Wishbone-to-peripheral-bus hub. Decodes a device index from the
//            address, drives one-hot per-device strobes, waits on the selected
//            device's busy with a timeout, registers its read data and
//            terminates unmapped or timed-out accesses with a Wishbone error.
// Ports    : wb_clk_i, wb_rst_i - clock, synchronous active-high reset
//            wb                 - Wishbone slave bundle
//            pb_we / pb_oe      - one-hot write / read strobes
//            pb_address, pb_byteSelect, pb_dataWrite - latched request fields
//            pb_busy, pb_dataRead - per-device busy and flattened read data
//            timeout_pulse      - one-cycle pulse on access timeout
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_bus_hub
  import peripheral_bus_pkg::*;
#(
  parameter int DEVICE_COUNT   = 4,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int DEVICE_SHIFT   = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  peripheral_bus_hub_if.slave                wb,
  output logic [DEVICE_COUNT-1:0]            pb_we,
  output logic [DEVICE_COUNT-1:0]            pb_oe,
  output logic [ADDR_WIDTH-1:0]              pb_address,
  output logic [DATA_WIDTH/8-1:0]            pb_byteSelect,
  output logic [DATA_WIDTH-1:0]              pb_dataWrite,
  input  logic [DEVICE_COUNT-1:0]            pb_busy,
  input  logic [DEVICE_COUNT*DATA_WIDTH-1:0] pb_dataRead,
  output logic                               timeout_pulse
);

  localparam logic [IDX_WIDTH:0]   c_dev_count    = (IDX_WIDTH+1)'(DEVICE_COUNT);
  // Timeout fires on the busy cycle that would bring the count to TIMEOUT_CYCLES
  localparam logic [CNT_WIDTH-1:0] c_timeout_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_we;
  logic                     r_err;
  logic [IDX_WIDTH-1:0]     r_idx;
  logic [CNT_WIDTH-1:0]     r_count;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_timeout;

  logic [IDX_WIDTH-1:0]     w_idx;
  logic                     w_mapped;
  logic                     w_req;
  logic                     w_busy;
  logic                     w_timeout;
  logic [DEVICE_COUNT-1:0]  w_onehot;
  logic [DATA_WIDTH-1:0]    w_slice;

  assign w_idx     = wb.wb_adr_i[DEVICE_SHIFT +: IDX_WIDTH];
  assign w_mapped  = {1'b0, w_idx} < c_dev_count;
  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i;
  // Masking with the one-hot select ignores busy from other devices
  assign w_busy    = |(pb_busy & w_onehot);
  assign w_timeout = w_busy && (r_count == c_timeout_last);
  assign timeout_pulse = r_timeout;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < DEVICE_COUNT; i++) begin
      w_onehot[i] = (r_idx == IDX_WIDTH'(i));
    end
  end

  peripheral_read_select #(
    .DEVICE_COUNT (DEVICE_COUNT),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_read_select (
    .idx      (r_idx),
    .data_in  (pb_dataRead),
    .data_out (w_slice)
  );

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and response outputs
  always_comb begin
    w_next           = r_state;
    wb.wb_stall_o    = 1'b0;
    wb.wb_ack_o      = 1'b0;
    wb.wb_error_o    = 1'b0;
    wb.wb_data_o     = '0;
    pb_we            = '0;
    pb_oe            = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_next = w_mapped ? ST_ACCESS : ST_RESPOND;
      end
      ST_ACCESS: begin
        wb.wb_stall_o = 1'b1;
        if (r_we) pb_we = w_onehot;
        else      pb_oe = w_onehot;
        // Master abandoning the cycle wins over completion and timeout
        if (!wb.wb_cyc_i)    w_next = ST_IDLE;
        else if (!w_busy)    w_next = ST_RESPOND;
        else if (w_timeout)  w_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        wb.wb_stall_o = 1'b1;
        wb.wb_ack_o   = ~r_err;
        wb.wb_error_o = r_err;
        if (!r_err && !r_we) wb.wb_data_o = r_rdata;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latches, capture register and timeout counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we          <= 1'b0;
      r_err         <= 1'b0;
      r_idx         <= '0;
      r_count       <= '0;
      r_rdata       <= '0;
      r_timeout     <= 1'b0;
      pb_address    <= '0;
      pb_byteSelect <= '0;
      pb_dataWrite  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_we          <= wb.wb_we_i;
            r_err         <= ~w_mapped;
            r_idx         <= w_idx;
            r_count       <= '0;
            pb_address    <= wb.wb_adr_i;
            pb_byteSelect <= wb.wb_sel_i;
            pb_dataWrite  <= wb.wb_data_i;
          end
        end
        ST_ACCESS: begin
          if (wb.wb_cyc_i) begin
            if (!w_busy) begin
              r_rdata <= w_slice;
            end else begin
              if (r_count != '1) r_count <= r_count + 1'b1;
              if (w_timeout) begin
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
